// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the HI/LO multiply/divide unit
package muldiv_pkg;

  // Operation encodings on the op input
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } stateT;

  // Default datapath width and the iteration counter width it implies
  localparam int MD_WIDTH = 32;
  localparam int CNT_W    = $clog2(MD_WIDTH);

  // Counter width for an arbitrary datapath width (one iteration per bit)
  function automatic int cntWidth(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/sign_mag_conv.sv
// rtl/sign_mag_conv.sv - conditional two's-complement negate, used for abs on entry and sign fix-up
module sign_mag_conv #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             negate,
  output logic [WIDTH-1:0] result
);

  // Abs of a negative value and negation of a magnitude are the same operation
  always_comb begin
    result = negate ? (~value + 1'b1) : value;
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - bit-serial multiply/divide unit owning the HI/LO register pair
module muldiv_hilo
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CntW = cntWidth(WIDTH);

  stateT                state;
  logic [CntW-1:0]      cnt;
  // MUL: {partial product high, multiplier shifting out}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0]   work;
  // Multiplicand magnitude for MUL, divisor magnitude for DIV
  logic [WIDTH-1:0]     opnd;
  logic [WIDTH-1:0]     rawA;
  logic                 negRes;
  logic                 negRem;
  logic                 bZero;
  logic                 isDiv;

  logic [WIDTH-1:0]     absA;
  logic [WIDTH-1:0]     absB;
  logic [2*WIDTH-1:0]   prodFix;
  logic [WIDTH-1:0]     quotFix;
  logic [WIDTH-1:0]     remFix;

  logic [WIDTH:0]       mulSum;
  logic [2*WIDTH-1:0]   mulNext;
  logic [WIDTH:0]       divShift;
  logic                 divGe;
  logic [WIDTH-1:0]     divDiff;
  logic [2*WIDTH-1:0]   divNext;

  sign_mag_conv #(.WIDTH(WIDTH)) uAbsA (
    .value  (A),
    .negate (sign & A[WIDTH-1]),
    .result (absA)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) uAbsB (
    .value  (B),
    .negate (sign & B[WIDTH-1]),
    .result (absB)
  );

  sign_mag_conv #(.WIDTH(2*WIDTH)) uNegProd (
    .value  (work),
    .negate (negRes),
    .result (prodFix)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) uNegQuot (
    .value  (work[WIDTH-1:0]),
    .negate (negRes),
    .result (quotFix)
  );

  sign_mag_conv #(.WIDTH(WIDTH)) uNegRem (
    .value  (work[2*WIDTH-1:WIDTH]),
    .negate (negRem),
    .result (remFix)
  );

  // One shift-add multiply step and one restoring divide step on the working register
  always_comb begin
    mulSum   = {1'b0, work[2*WIDTH-1:WIDTH]} + (work[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mulNext  = {mulSum, work[WIDTH-1:1]};
    divShift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
    divGe    = (divShift >= {1'b0, opnd});
    // When the trial subtract succeeds the difference is below the divisor, so WIDTH bits suffice
    divDiff  = divShift[WIDTH-1:0] - opnd;
    divNext  = {(divGe ? divDiff : divShift[WIDTH-1:0]), work[WIDTH-2:0], divGe};
  end

  // Sequencer, iteration datapath and HI/LO registers with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      work        <= '0;
      opnd        <= '0;
      rawA        <= '0;
      negRes      <= 1'b0;
      negRem      <= 1'b0;
      bZero       <= 1'b0;
      isDiv       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_DIV: begin
                isDiv  <= (op == OP_DIV);
                work   <= (op == OP_DIV) ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                opnd   <= (op == OP_DIV) ? absB : absA;
                rawA   <= A;
                negRes <= sign & (A[WIDTH-1] ^ B[WIDTH-1]);
                negRem <= sign & A[WIDTH-1];
                bZero  <= (B == '0);
                cnt    <= '0;
                busy   <= 1'b1;
                state  <= (op == OP_DIV) ? ST_DIV : ST_MUL;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          work <= mulNext;
          cnt  <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH-1)) state <= ST_FIX;
        end
        ST_DIV: begin
          work <= divNext;
          cnt  <= cnt + 1'b1;
          if (cnt == CntW'(WIDTH-1)) state <= ST_FIX;
        end
        ST_FIX: begin
          if (isDiv && bZero) begin
            lo          <= '1;
            hi          <= rawA;
            div_by_zero <= 1'b1;
          end else if (isDiv) begin
            lo          <= quotFix;
            hi          <= remFix;
            div_by_zero <= 1'b0;
          end else begin
            {hi, lo}    <= prodFix;
            div_by_zero <= 1'b0;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
